// File: rtl/knap_seq_eval.sv
// knap_seq_eval: sequential multi-constraint knapsack candidate evaluator with programmable coefficients.
module knap_seq_eval #(
  parameter int N_ITEMS = 12,
  parameter int N_DIM = 2,
  parameter int VW = 8,
  parameter int ACC_W = 12,
  localparam int AW = $clog2(N_ITEMS + 1),
  localparam int FW = $clog2(N_DIM + 1),
  localparam int IW = $clog2(N_ITEMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [FW-1:0]    cfg_field,
  input  logic [ACC_W-1:0] cfg_data,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_ITEMS-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_value,
  output logic             out_value_ok,
  output logic [N_DIM-1:0] out_cap_ok,
  output logic             out_feasible
);
  typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [N_ITEMS-1:0] sel;
  logic [VW-1:0] coef [N_ITEMS][N_DIM+1];
  // thr[0] is min_value, thr[d+1] is the limit for capacity dim d
  logic [ACC_W-1:0] thr [N_DIM+1];
  logic [ACC_W-1:0] acc [N_DIM+1];
  logic val_ok_c;
  logic [N_DIM-1:0] cap_ok_c;
  logic wr_ok;
  assign in_ready = state == IDLE;
  assign wr_ok = cfg_we && state == IDLE && cfg_addr <= AW'(N_ITEMS) && cfg_field <= FW'(N_DIM);
  always_comb begin
    val_ok_c = acc[0] >= thr[0];
    cap_ok_c = '0;
    for (int d = 0; d < N_DIM; d++) cap_ok_c[d] = acc[d+1] <= thr[d+1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      sel <= '0;
      cfg_err <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_value_ok <= 1'b0;
      out_cap_ok <= '0;
      out_feasible <= 1'b0;
      for (int k = 0; k <= N_DIM; k++) begin
        thr[k] <= '0;
        acc[k] <= '0;
        for (int i = 0; i < N_ITEMS; i++) coef[i][k] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && !wr_ok;
      if (wr_ok) begin
        if (cfg_addr == AW'(N_ITEMS)) thr[cfg_field] <= cfg_data;
        else coef[cfg_addr[IW-1:0]][cfg_field] <= cfg_data[VW-1:0];
      end
      case (state)
        IDLE: if (in_valid) begin
          sel <= in_sel;
          idx <= '0;
          for (int k = 0; k <= N_DIM; k++) acc[k] <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          // zero-extended add; ACC_W is sized so the full sum never wraps
          if (sel[idx]) for (int k = 0; k <= N_DIM; k++) acc[k] <= acc[k] + ACC_W'(coef[idx][k]);
          idx <= idx + IW'(1);
          if (idx == IW'(N_ITEMS - 1)) state <= CMP;
        end
        CMP: begin
          out_value <= acc[0];
          out_value_ok <= val_ok_c;
          out_cap_ok <= cap_ok_c;
          out_feasible <= val_ok_c && &cap_ok_c;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_knap_seq_eval.sv
// tb_knap_seq_eval: directed self-checking bench for knap_seq_eval at default parameters.
module tb_knap_seq_eval;
  logic clk = 0, rst_n = 0;
  logic cfg_we = 0;
  logic [3:0] cfg_addr = 0;
  logic [1:0] cfg_field = 0;
  logic [11:0] cfg_data = 0;
  logic cfg_err, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [11:0] in_sel = 0, out_value;
  logic out_value_ok, out_feasible;
  logic [1:0] out_cap_ok;
  int checks = 0, errors = 0;

  knap_seq_eval dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_field(cfg_field),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_value_ok(out_value_ok), .out_cap_ok(out_cap_ok), .out_feasible(out_feasible)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int f, input int d);
    cfg_we = 1; cfg_addr = 4'(a); cfg_field = 2'(f); cfg_data = 12'(d);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic start(input logic [11:0] s);
    in_valid = 1; in_sel = s;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 13);
  endtask

  task automatic check_out(input string tag, input int v, input int vok, input int cap, input int feas);
    chk({tag, "_value"}, out_value, v);
    chk({tag, "_value_ok"}, out_value_ok, vok);
    chk({tag, "_cap_ok"}, out_cap_ok, cap);
    chk({tag, "_feasible"}, out_feasible, feas);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_ready_back"}, in_ready, 1);
    chk({tag, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic run(input string tag, input logic [11:0] s, input int v, input int vok, input int cap, input int feas);
    start(s);
    chk({tag, "_busy"}, in_ready, 0);
    wait_valid(tag);
    check_out(tag, v, vok, cap, feas);
    release_out(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_cap_ok", out_cap_ok, 0);
    chk("rst_feasible", out_feasible, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1;
    @(negedge clk);

    run("empty", 12'h000, 0, 1, 2'b11, 1);

    for (int i = 0; i < 12; i++) begin
      wr(i, 0, i + 1);
      wr(i, 1, 5);
      wr(i, 2, 5);
    end
    wr(12, 0, 20);
    wr(12, 1, 60);
    wr(12, 2, 60);
    chk("good_wr_no_err", cfg_err, 0);
    run("eq_limits", 12'hFFF, 78, 1, 2'b11, 1);

    wr(0, 1, 6);
    run("dim0_over", 12'hFFF, 78, 1, 2'b10, 0);
    run("low_value", 12'h001, 1, 0, 2'b11, 0);

    wr(13, 0, 1);
    chk("bad_addr_err", cfg_err, 1);
    @(negedge clk);
    chk("bad_addr_err_pulse", cfg_err, 0);
    wr(3, 3, 1);
    chk("bad_field_err", cfg_err, 1);
    run("after_bad_wr", 12'h001, 1, 0, 2'b11, 0);

    for (int i = 0; i < 12; i++) begin
      wr(i, 0, 255);
      wr(i, 1, 255);
      wr(i, 2, 255);
    end
    wr(12, 0, 3060);
    wr(12, 1, 4095);
    wr(12, 2, 4095);
    run("max_coef", 12'hFFF, 3060, 1, 2'b11, 1);

    start(12'hFFF);
    @(negedge clk);
    wr(0, 0, 0);
    chk("busy_wr_err", cfg_err, 1);
    @(negedge clk);
    chk("busy_wr_err_pulse", cfg_err, 0);
    begin
      int n = 3;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("bp_latency", n, 13);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_value_hold", out_value, 3060);
      chk("bp_in_ready", in_ready, 0);
    end
    release_out("bp");
    run("table_kept", 12'hFFF, 3060, 1, 2'b11, 1);

    start(12'hFFF);
    repeat (6) @(negedge clk);
    chk("pre_abort_busy", in_ready, 0);
    #2 rst_n = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run("after_abort", 12'hFFF, 0, 1, 2'b11, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
